// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register for the vector ASIP datapath.
// Captures scalar, vector and control fields on enabled edges; a stall holds them and reset clears them.
module pipe_ex_mem #(
  parameter int N = 32,
  parameter int V = 20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable_i,
  input  logic [N-1:0]          RD1_S_i,
  input  logic [N-1:0]          RD2_S_i,
  input  logic [N-1:0]          AluResult_S_i,
  input  logic                  RegFile_WE_i,
  input  logic                  MemWE_i,
  input  logic                  WBSelect_i,
  input  logic                  OpSource_i,
  input  logic [3:0]            A3_i,
  input  logic [1:0]            OpType_i,
  input  logic [V-1:0][N-1:0]   RD1_V_i,
  input  logic [V-1:0][N-1:0]   RD2_V_i,
  input  logic [V-1:0][N-1:0]   AluResult_V_i,
  output logic [N-1:0]          RD1_S_o,
  output logic [N-1:0]          RD2_S_o,
  output logic [N-1:0]          AluResult_S_o,
  output logic                  RegFile_WE_o,
  output logic                  MemWE_o,
  output logic                  WBSelect_o,
  output logic                  OpSource_o,
  output logic [3:0]            A3_o,
  output logic [1:0]            OpType_o,
  output logic [V-1:0][N-1:0]   RD1_V_o,
  output logic [V-1:0][N-1:0]   RD2_V_o,
  output logic [V-1:0][N-1:0]   AluResult_V_o
);

  logic [N-1:0]        r_rd1_s;
  logic [N-1:0]        r_rd2_s;
  logic [N-1:0]        r_alu_s;
  logic                r_rf_we;
  logic                r_mem_we;
  logic                r_wb_sel;
  logic                r_op_src;
  logic [3:0]          r_a3;
  logic [1:0]          r_op_type;
  logic [V-1:0][N-1:0] r_rd1_v;
  logic [V-1:0][N-1:0] r_rd2_v;
  logic [V-1:0][N-1:0] r_alu_v;

  // Reset clears to a no-op bundle (no RF write, no memory write); stall holds everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd1_s   <= '0;
      r_rd2_s   <= '0;
      r_alu_s   <= '0;
      r_rf_we   <= 1'b0;
      r_mem_we  <= 1'b0;
      r_wb_sel  <= 1'b0;
      r_op_src  <= 1'b0;
      r_a3      <= 4'd0;
      r_op_type <= 2'd0;
      r_rd1_v   <= '0;
      r_rd2_v   <= '0;
      r_alu_v   <= '0;
    end else if (enable_i) begin
      r_rd1_s   <= RD1_S_i;
      r_rd2_s   <= RD2_S_i;
      r_alu_s   <= AluResult_S_i;
      r_rf_we   <= RegFile_WE_i;
      r_mem_we  <= MemWE_i;
      r_wb_sel  <= WBSelect_i;
      r_op_src  <= OpSource_i;
      r_a3      <= A3_i;
      r_op_type <= OpType_i;
      r_rd1_v   <= RD1_V_i;
      r_rd2_v   <= RD2_V_i;
      r_alu_v   <= AluResult_V_i;
    end else begin
      r_rd1_s   <= r_rd1_s;
      r_rd2_s   <= r_rd2_s;
      r_alu_s   <= r_alu_s;
      r_rf_we   <= r_rf_we;
      r_mem_we  <= r_mem_we;
      r_wb_sel  <= r_wb_sel;
      r_op_src  <= r_op_src;
      r_a3      <= r_a3;
      r_op_type <= r_op_type;
      r_rd1_v   <= r_rd1_v;
      r_rd2_v   <= r_rd2_v;
      r_alu_v   <= r_alu_v;
    end
  end

  assign RD1_S_o       = r_rd1_s;
  assign RD2_S_o       = r_rd2_s;
  assign AluResult_S_o = r_alu_s;
  assign RegFile_WE_o  = r_rf_we;
  assign MemWE_o       = r_mem_we;
  assign WBSelect_o    = r_wb_sel;
  assign OpSource_o    = r_op_src;
  assign A3_o          = r_a3;
  assign OpType_o      = r_op_type;
  assign RD1_V_o       = r_rd1_v;
  assign RD2_V_o       = r_rd2_v;
  assign AluResult_V_o = r_alu_v;

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Directed bench for pipe_ex_mem: expected bundles are queued when stimulus is applied
// and popped/compared one cycle later against the registered outputs.
module tb_pipe_ex_mem;
  localparam int N = 32;
  localparam int V = 20;
  localparam int W = V * N;

  typedef struct packed {
    logic [N-1:0]        rd1_s;
    logic [N-1:0]        rd2_s;
    logic [N-1:0]        alu_s;
    logic                rf_we;
    logic                mem_we;
    logic                wb_sel;
    logic                op_src;
    logic [3:0]          a3;
    logic [1:0]          op_type;
    logic [V-1:0][N-1:0] rd1_v;
    logic [V-1:0][N-1:0] rd2_v;
    logic [V-1:0][N-1:0] alu_v;
  } rec_t;

  logic CLK = 1'b0;
  logic RST;
  logic enable_i;
  logic [N-1:0] RD1_S_i, RD2_S_i, AluResult_S_i;
  logic RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i;
  logic [3:0] A3_i;
  logic [1:0] OpType_i;
  logic [V-1:0][N-1:0] RD1_V_i, RD2_V_i, AluResult_V_i;
  logic [N-1:0] RD1_S_o, RD2_S_o, AluResult_S_o;
  logic RegFile_WE_o, MemWE_o, WBSelect_o, OpSource_o;
  logic [3:0] A3_o;
  logic [1:0] OpType_o;
  logic [V-1:0][N-1:0] RD1_V_o, RD2_V_o, AluResult_V_o;

  int checks = 0;
  int failures = 0;
  rec_t model = '0;
  rec_t sb_q[$];

  always #5 CLK = ~CLK;

  pipe_ex_mem #(.N(N), .V(V)) dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i),
    .RD1_S_i(RD1_S_i), .RD2_S_i(RD2_S_i), .AluResult_S_i(AluResult_S_i),
    .RegFile_WE_i(RegFile_WE_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
    .OpSource_i(OpSource_i), .A3_i(A3_i), .OpType_i(OpType_i),
    .RD1_V_i(RD1_V_i), .RD2_V_i(RD2_V_i), .AluResult_V_i(AluResult_V_i),
    .RD1_S_o(RD1_S_o), .RD2_S_o(RD2_S_o), .AluResult_S_o(AluResult_S_o),
    .RegFile_WE_o(RegFile_WE_o), .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o),
    .OpSource_o(OpSource_o), .A3_o(A3_o), .OpType_o(OpType_o),
    .RD1_V_o(RD1_V_o), .RD2_V_o(RD2_V_o), .AluResult_V_o(AluResult_V_o)
  );

  function automatic rec_t cur_inputs();
    rec_t r;
    r.rd1_s = RD1_S_i;  r.rd2_s = RD2_S_i;  r.alu_s = AluResult_S_i;
    r.rf_we = RegFile_WE_i;  r.mem_we = MemWE_i;  r.wb_sel = WBSelect_i;
    r.op_src = OpSource_i;  r.a3 = A3_i;  r.op_type = OpType_i;
    r.rd1_v = RD1_V_i;  r.rd2_v = RD2_V_i;  r.alu_v = AluResult_V_i;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input rec_t e);
    chk({tag, ".RD1_S"}, W'(RD1_S_o), W'(e.rd1_s));
    chk({tag, ".RD2_S"}, W'(RD2_S_o), W'(e.rd2_s));
    chk({tag, ".ALU_S"}, W'(AluResult_S_o), W'(e.alu_s));
    chk({tag, ".RF_WE"}, W'(RegFile_WE_o), W'(e.rf_we));
    chk({tag, ".MEM_WE"}, W'(MemWE_o), W'(e.mem_we));
    chk({tag, ".WBSEL"}, W'(WBSelect_o), W'(e.wb_sel));
    chk({tag, ".OPSRC"}, W'(OpSource_o), W'(e.op_src));
    chk({tag, ".A3"}, W'(A3_o), W'(e.a3));
    chk({tag, ".OPTYPE"}, W'(OpType_o), W'(e.op_type));
    chk({tag, ".RD1_V"}, RD1_V_o, e.rd1_v);
    chk({tag, ".RD2_V"}, RD2_V_o, e.rd2_v);
    chk({tag, ".ALU_V"}, AluResult_V_o, e.alu_v);
  endtask

  // One clock edge: model the expected bundle, queue it, then pop and compare after the edge.
  task automatic step(input string tag);
    rec_t e;
    if (!RST) model = '0;
    else if (enable_i) model = cur_inputs();
    sb_q.push_back(model);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_rec(tag, e);
  endtask

  task automatic randomize_inputs();
    RD1_S_i = $urandom;  RD2_S_i = $urandom;  AluResult_S_i = $urandom;
    RegFile_WE_i = 1'($urandom);  MemWE_i = 1'($urandom);
    WBSelect_i = 1'($urandom);  OpSource_i = 1'($urandom);
    A3_i = 4'($urandom);  OpType_i = 2'($urandom);
    for (int i = 0; i < V; i++) begin
      RD1_V_i[i] = $urandom;  RD2_V_i[i] = $urandom;  AluResult_V_i[i] = $urandom;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset with nonzero inputs and enable high.
    RST = 1'b0;  enable_i = 1'b1;
    RD1_S_i = '0;  RD2_S_i = '0;  AluResult_S_i = '0;
    RegFile_WE_i = 1'b0;  MemWE_i = 1'b0;  WBSelect_i = 1'b0;  OpSource_i = 1'b0;
    A3_i = 4'd0;  OpType_i = 2'd0;
    RD1_V_i = '0;  RD2_V_i = '0;  AluResult_V_i = '0;
    RD1_S_i = 32'd4;  MemWE_i = 1'b1;  A3_i = 4'd5;
    #2;
    check_rec("reset_pre_edge", rec_t'(0));
    step("reset_edge");
    step("reset_edge2");

    // Release reset between edges and load.
    #2;
    RST = 1'b1;
    RD1_S_i = 32'd1;  MemWE_i = 1'b0;  A3_i = 4'd0;
    step("load1");
    RD1_S_i = 32'd2;
    step("load2");

    // Multi-cycle stall while inputs keep changing.
    enable_i = 1'b0;
    RD1_S_i = 32'd3;
    step("stall1");
    randomize_inputs();
    #2;
    check_rec("stall_mid", model);
    step("stall2");
    randomize_inputs();
    step("stall3");

    // Resume loading with random data.
    enable_i = 1'b1;
    step("resume");

    // Asynchronous reset between edges.
    #2;
    RST = 1'b0;
    #1;
    model = '0;
    check_rec("async_rst", model);
    step("rst_hold_en");
    #2;
    RST = 1'b1;
    enable_i = 1'b1;
    RD1_S_i = 32'd4;
    step("rst_release_load");

    // All fields together, lane ordering.
    RD1_S_i = 32'd0;  RD2_S_i = 32'd0;
    AluResult_S_i = 32'hDEADBEEF;  A3_i = 4'hF;  OpType_i = 2'b10;
    RegFile_WE_i = 1'b1;  MemWE_i = 1'b1;  WBSelect_i = 1'b1;  OpSource_i = 1'b1;
    RD1_V_i = '0;  RD2_V_i = '0;  AluResult_V_i = '0;
    RD1_V_i[0] = 32'd1;        RD1_V_i[V-1] = 32'hFFFFFFFF;
    RD2_V_i[0] = 32'd1;        RD2_V_i[V-1] = 32'hFFFFFFFF;
    AluResult_V_i[0] = 32'd1;  AluResult_V_i[V-1] = 32'hFFFFFFFF;
    step("all_fields");

    // Lane isolation: RD2 lanes carry their index, other vectors distinct patterns.
    for (int i = 0; i < V; i++) begin
      RD2_V_i[i] = 32'(i);
      RD1_V_i[i] = 32'hA5A50000 | 32'(i);
      AluResult_V_i[i] = 32'h5A5A0000 | 32'(i);
    end
    step("lane_iso");
    for (int i = 0; i < V; i++) begin
      chk($sformatf("lane%0d", i), W'(RD2_V_o[i]), W'(i));
    end

    // Random mix of loads and stalls.
    for (int k = 0; k < 20; k++) begin
      randomize_inputs();
      enable_i = 1'($urandom);
      step($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
